// File: rtl/cpu_stack_unit_if.sv
// Bus bundle for cpu_stack_unit: operation request inputs and stack status outputs.
interface cpu_stack_unit_if #(
    parameter int DATA_W   = 35,
    parameter int DEPTH    = 64,
    parameter int POP_MAX  = 3,
    parameter int PUSH_MAX = 3,
    parameter int READ_N   = 2
);
    localparam int SP_W = $clog2(DEPTH) + 1;
    localparam int PC_W = $clog2(POP_MAX + 1);
    localparam int HC_W = $clog2(PUSH_MAX + 1);

    logic [PC_W-1:0]            pop_cnt;
    logic [HC_W-1:0]            push_cnt;
    logic [PUSH_MAX*DATA_W-1:0] push_data;
    logic                       save;
    logic                       restore;
    logic                       err_clr;
    logic [READ_N*DATA_W-1:0]   top;
    logic [SP_W-1:0]            sp;
    logic [SP_W-1:0]            saved_sp;
    logic                       empty;
    logic                       full;
    logic                       underflow_err;
    logic                       overflow_err;

    modport master (
        output pop_cnt, push_cnt, push_data, save, restore, err_clr,
        input  top, sp, saved_sp, empty, full, underflow_err, overflow_err
    );

    modport slave (
        input  pop_cnt, push_cnt, push_data, save, restore, err_clr,
        output top, sp, saved_sp, empty, full, underflow_err, overflow_err
    );
endinterface

// File: rtl/cpu_stack_unit.sv
// Multi-pop/multi-push register-array stack with checkpoint/rollback of the
// stack pointer and sticky under/overflow flags.
module cpu_stack_unit #(
    parameter int DATA_W   = 35,
    parameter int DEPTH    = 64,
    parameter int POP_MAX  = 3,
    parameter int PUSH_MAX = 3,
    parameter int READ_N   = 2
) (
    input logic              i_clk,
    input logic              i_rst,
    cpu_stack_unit_if.slave  bus
);
    localparam int AW   = $clog2(DEPTH);
    localparam int SP_W = AW + 1;
    localparam int PC_W = $clog2(POP_MAX + 1);
    localparam int HC_W = $clog2(PUSH_MAX + 1);
    // Wide enough that sp - pop + push never wraps for any input encoding.
    localparam int EW   = SP_W + PC_W + HC_W + 1;

    localparam logic signed [EW-1:0] DEPTH_E    = $signed(EW'(DEPTH));
    localparam logic signed [EW-1:0] POP_MAX_E  = $signed(EW'(POP_MAX));
    localparam logic signed [EW-1:0] PUSH_MAX_E = $signed(EW'(PUSH_MAX));

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [SP_W-1:0]   r_sp;
    logic [SP_W-1:0]   r_saved_sp;
    logic              r_uf;
    logic              r_of;

    logic signed [EW-1:0]           w_sp_e;
    logic signed [EW-1:0]           w_pop_e;
    logic signed [EW-1:0]           w_push_e;
    logic signed [EW-1:0]           w_base_e;
    logic signed [EW-1:0]           w_sum_e;
    logic                           w_uf;
    logic                           w_of;
    logic                           w_ok;
    logic [SP_W-1:0]                w_sp_next;
    logic [PUSH_MAX-1:0]            w_we;
    logic [PUSH_MAX-1:0][AW-1:0]    w_waddr;
    logic [READ_N-1:0][DATA_W-1:0]  w_top;

    // Signed arithmetic so an over-pop shows up as a negative base rather than a wrap.
    assign w_sp_e   = $signed(EW'(r_sp));
    assign w_pop_e  = $signed(EW'(bus.pop_cnt));
    assign w_push_e = $signed(EW'(bus.push_cnt));
    assign w_base_e = w_sp_e - w_pop_e;
    assign w_sum_e  = w_base_e + w_push_e;

    assign w_uf = (w_pop_e > POP_MAX_E) || (w_pop_e > w_sp_e);
    assign w_of = (w_push_e > PUSH_MAX_E) || (w_sum_e > DEPTH_E);
    // Restore kills the operation outright; any error discards it whole.
    assign w_ok = !bus.restore && !w_uf && !w_of;

    assign w_sp_next = w_ok ? SP_W'(w_sum_e) : r_sp;

    // Push slot i lands just above the post-pop top, so the last slot ends up on top.
    for (genvar i = 0; i < PUSH_MAX; i++) begin : g_wr
        assign w_we[i]    = w_ok && (bus.push_cnt > HC_W'(i));
        assign w_waddr[i] = AW'(w_base_e + EW'(i));
    end

    // Array write: no reset on storage; reset still blocks the write.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            for (int i = 0; i < PUSH_MAX; i++) begin
                if (w_we[i]) r_mem[w_waddr[i]] <= bus.push_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Pointer, checkpoint and sticky error state; error set wins over clear.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sp       <= '0;
            r_saved_sp <= '0;
            r_uf       <= 1'b0;
            r_of       <= 1'b0;
        end else begin
            if (bus.restore) begin
                r_sp <= r_saved_sp;
            end else begin
                r_sp <= w_sp_next;
                if (bus.save) r_saved_sp <= w_sp_next;
            end
            r_uf <= (r_uf && !bus.err_clr) || (!bus.restore && w_uf);
            r_of <= (r_of && !bus.err_clr) || (!bus.restore && w_of);
        end
    end

    // Top-of-stack read ports; slots below the bottom read as zero so dead entries never leak.
    always_comb begin
        w_top = '0;
        for (int k = 0; k < READ_N; k++) begin
            if (r_sp > SP_W'(k)) w_top[k] = r_mem[AW'(r_sp - SP_W'(k) - SP_W'(1))];
        end
    end

    assign bus.top           = w_top;
    assign bus.sp            = r_sp;
    assign bus.saved_sp      = r_saved_sp;
    assign bus.empty         = (r_sp == '0);
    assign bus.full          = (r_sp == SP_W'(DEPTH));
    assign bus.underflow_err = r_uf;
    assign bus.overflow_err  = r_of;
endmodule

// File: tb/tb_cpu_stack_unit.sv
// Scoreboard bench for cpu_stack_unit: directed scenarios plus biased random
// traffic, checked against an array-and-counter reference model.
module tb_cpu_stack_unit;
    localparam int DW       = 35;
    localparam int DEPTH    = 64;
    localparam int POP_MAX  = 3;
    localparam int PUSH_MAX = 3;
    localparam int READ_N   = 2;
    localparam int SP_W     = $clog2(DEPTH) + 1;
    localparam int PC_W     = $clog2(POP_MAX + 1);
    localparam int HC_W     = $clog2(PUSH_MAX + 1);

    typedef logic [PUSH_MAX-1:0][DW-1:0] pdata_t;
    typedef struct {
        int                        sp;
        int                        ssp;
        bit                        uf;
        bit                        of;
        bit                        emp;
        bit                        ful;
        logic [READ_N-1:0][DW-1:0] top;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cpu_stack_unit_if #(.DATA_W(DW), .DEPTH(DEPTH), .POP_MAX(POP_MAX),
                        .PUSH_MAX(PUSH_MAX), .READ_N(READ_N)) bus ();

    cpu_stack_unit #(.DATA_W(DW), .DEPTH(DEPTH), .POP_MAX(POP_MAX),
                     .PUSH_MAX(PUSH_MAX), .READ_N(READ_N)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    // Reference model: plain array + occupancy count.
    logic [DW-1:0] m_mem [DEPTH];
    int m_sp = 0, m_ssp = 0;
    bit m_uf = 0, m_of = 0;
    exp_t q[$];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] rd();
        logic [63:0] v;
        v = {$urandom(), $urandom()};
        return v[DW-1:0];
    endfunction

    // Apply one cycle of inputs, advance the model, queue the expected post-edge state.
    task automatic step(input int pop, input int push, input bit sv, input bit rs,
                        input bit clr, input bit r, input pdata_t d);
        exp_t e;
        bit ue, oe;
        rst           = r;
        bus.pop_cnt   = PC_W'(pop);
        bus.push_cnt  = HC_W'(push);
        bus.push_data = d;
        bus.save      = sv;
        bus.restore   = rs;
        bus.err_clr   = clr;

        if (r) begin
            m_sp = 0; m_ssp = 0; m_uf = 0; m_of = 0;
        end else if (rs) begin
            m_sp = m_ssp;
            if (clr) begin m_uf = 0; m_of = 0; end
        end else begin
            ue = (pop > m_sp) || (pop > POP_MAX);
            oe = (push > PUSH_MAX) || (m_sp - pop + push > DEPTH);
            if (!ue && !oe) begin
                for (int i = 0; i < push; i++) m_mem[m_sp - pop + i] = d[i];
                m_sp = m_sp - pop + push;
            end
            if (sv) m_ssp = m_sp;
            m_uf = (m_uf && !clr) || ue;
            m_of = (m_of && !clr) || oe;
        end

        e.sp  = m_sp;
        e.ssp = m_ssp;
        e.uf  = m_uf;
        e.of  = m_of;
        e.emp = (m_sp == 0);
        e.ful = (m_sp == DEPTH);
        for (int k = 0; k < READ_N; k++) e.top[k] = (k < m_sp) ? m_mem[m_sp - 1 - k] : '0;
        q.push_back(e);

        @(posedge clk);
        #2;
    endtask

    function automatic pdata_t pd(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [DW-1:0] c);
        pdata_t d;
        d[0] = a; d[1] = b; d[2] = c;
        return d;
    endfunction

    function automatic pdata_t rpd();
        return pd(rd(), rd(), rd());
    endfunction

    // Monitor: every cycle just after the edge, compare DUT state with the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("sp",        64'(bus.sp),            64'(e.sp));
                chk("saved_sp",  64'(bus.saved_sp),      64'(e.ssp));
                chk("underflow", 64'(bus.underflow_err), 64'(e.uf));
                chk("overflow",  64'(bus.overflow_err),  64'(e.of));
                chk("empty",     64'(bus.empty),         64'(e.emp));
                chk("full",      64'(bus.full),          64'(e.ful));
                for (int k = 0; k < READ_N; k++)
                    chk($sformatf("top%0d", k), 64'(bus.top[k*DW +: DW]), 64'(e.top[k]));
            end
        end
    end

    initial begin
        int mode;
        int wait_cnt;
        // Reset, then push A,B,C.
        step(0, 0, 0, 0, 0, 1, '0);
        step(0, 3, 0, 0, 0, 0, pd(35'hA, 35'hB, 35'hC));
        // Pop 2 push D.
        step(2, 1, 0, 0, 0, 0, pd(35'hD, 35'h0, 35'h0));
        // Down to sp=1, then over-pop, then clear.
        step(1, 0, 0, 0, 0, 0, '0);
        step(2, 1, 0, 0, 0, 0, pd(35'hE, 35'h0, 35'h0));
        step(0, 0, 0, 0, 1, 0, '0);
        // Fill to 63, overflow by 2, then fill exactly.
        step(0, 0, 0, 0, 0, 1, '0);
        for (int i = 0; i < 21; i++) step(0, 3, 0, 0, 0, 0, rpd());
        step(0, 2, 0, 0, 0, 0, rpd());
        step(0, 1, 0, 0, 0, 0, rpd());
        step(0, 1, 0, 0, 1, 0, rpd());
        step(3, 0, 0, 0, 0, 0, '0);
        // Checkpoint at 5, push 2, pop 1, restore with a push request.
        step(0, 0, 0, 0, 1, 1, '0);
        step(0, 3, 0, 0, 0, 0, rpd());
        step(0, 2, 0, 0, 0, 0, rpd());
        step(0, 0, 1, 0, 0, 0, '0);
        step(0, 2, 0, 0, 0, 0, rpd());
        step(1, 0, 0, 0, 0, 0, '0);
        step(0, 3, 0, 1, 0, 0, rpd());
        // Reset beats restore and push.
        step(0, 2, 1, 1, 0, 0, rpd());
        step(0, 2, 0, 1, 0, 1, rpd());
        // Save together with a discarded op keeps the unchanged sp.
        step(0, 2, 0, 0, 0, 0, rpd());
        step(3, 0, 1, 0, 0, 0, '0);
        step(0, 0, 0, 0, 1, 0, '0);

        // Random traffic, alternating push-heavy and pop-heavy phases.
        for (int cyc = 0; cyc < 1200; cyc++) begin
            mode = (cyc / 40) % 2;
            step(mode ? $urandom_range(0, 1) : $urandom_range(0, 3),
                 mode ? $urandom_range(1, 3) : $urandom_range(0, 2),
                 $urandom_range(0, 7) == 0,
                 $urandom_range(0, 11) == 0,
                 $urandom_range(0, 5) == 0,
                 $urandom_range(0, 299) == 0,
                 rpd());
        end
        step(0, 0, 0, 0, 0, 0, '0);

        wait_cnt = 0;
        while (q.size() > 0 && wait_cnt < 10) begin
            @(posedge clk);
            wait_cnt++;
        end
        #3;
        chk("drain", 64'(q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
